// File: rtl/rle_line_encoder.sv
// Byte-stream run-length encoder: folds equal consecutive bytes into {count, value} pairs and packs them into lines.
// Optional counters stat_pairs/stat_bytes are built only when RLE_LINE_ENCODER_STATS_EN is defined.
module rle_line_encoder #(
  parameter  int unsigned DATA_WIDTH  = 512,
  parameter  int unsigned COUNT_WIDTH = 8,
  localparam int unsigned PAIR_W      = 8 + COUNT_WIDTH,
  localparam int unsigned PAIRS       = DATA_WIDTH / PAIR_W,
  localparam int unsigned NUM_W       = $clog2(PAIRS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [NUM_W-1:0]      out_num_pairs,
  output logic [31:0]           stat_pairs,
  output logic [31:0]           stat_bytes
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = '1;
  localparam logic [NUM_W-1:0]       FULL_N  = NUM_W'(PAIRS);

  logic [1:0]             state;
  logic [1:0]             next_state;
  logic [7:0]             cur_val;
  logic [COUNT_WIDTH-1:0] cur_cnt;
  logic [DATA_WIDTH-1:0]  line_buf;
  logic [DATA_WIDTH-1:0]  buf_next;
  logic [NUM_W-1:0]       n;
  logic [NUM_W-1:0]       n_inc;

  logic accept;
  logic drain;
  logic append;
  logic extend;
  logic open_run;

  assign in_ready = !out_valid && (state != S_TAIL);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign n_inc    = n + NUM_W'(1);

  always_comb begin
    next_state = state;
    append     = 1'b0;
    extend     = 1'b0;
    open_run   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          open_run   = 1'b1;
          next_state = in_last ? S_TAIL : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (in_data == cur_val && cur_cnt != MAX_CNT) begin
            extend = 1'b1;
          end else begin
            append   = 1'b1;
            open_run = 1'b1;
          end
          if (in_last) next_state = S_TAIL;
        end
      end
      S_TAIL: begin
        // Waits while a full line is still pending; the tail then starts a fresh line.
        if (!out_valid) begin
          append     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    buf_next = line_buf;
    for (int unsigned k = 0; k < PAIRS; k++) begin
      if (n == NUM_W'(k)) buf_next[k*PAIR_W +: PAIR_W] = {cur_cnt, cur_val};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_val   <= '0;
      cur_cnt   <= '0;
      line_buf  <= '0;
      n         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= next_state;

      // Drain and append never coincide: every append path requires out_valid low.
      if (drain) begin
        line_buf  <= '0;
        n         <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (append) begin
        line_buf <= buf_next;
        n        <= n_inc;
        if (state == S_TAIL) begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
        end else if (n_inc == FULL_N) begin
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end
      end

      if (open_run) begin
        cur_val <= in_data;
        cur_cnt <= COUNT_WIDTH'(1);
      end else if (extend) begin
        cur_cnt <= cur_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign out_data      = line_buf;
  assign out_num_pairs = n;

`ifdef RLE_LINE_ENCODER_STATS_EN
  logic [31:0] pairs_cnt;
  logic [31:0] bytes_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pairs_cnt <= '0;
      bytes_cnt <= '0;
    end else begin
      if (append) pairs_cnt <= pairs_cnt + 32'd1;
      if (accept) bytes_cnt <= bytes_cnt + 32'd1;
    end
  end

  assign stat_pairs = pairs_cnt;
  assign stat_bytes = bytes_cnt;
`else
  assign stat_pairs = '0;
  assign stat_bytes = '0;
`endif

endmodule

// File: tb/tb_rle_line_encoder.sv
// Self-checking bench for rle_line_encoder: directed vector table, hand-written corner sequences,
// and randomized streams checked against a run-list/line-chunking reference model.
module tb_rle_line_encoder;

  localparam int DW   = 512;
  localparam int CW   = 8;
  localparam int PW   = 8 + CW;
  localparam int NP   = DW / PW;
  localparam int MAXC = (1 << CW) - 1;
  localparam int NW   = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [NW-1:0] out_num_pairs;
  logic [31:0]   stat_pairs;
  logic [31:0]   stat_bytes;

  always #5 clk = ~clk;

  rle_line_encoder #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_num_pairs(out_num_pairs), .stat_pairs(stat_pairs), .stat_bytes(stat_bytes)
  );

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   num;
    int unsigned   last;
  } line_t;

  typedef struct {
    int unsigned nr;
    logic [7:0]  val[3];
    int unsigned len[3];
    int unsigned num;
    logic [15:0] p[3];
    int unsigned last;
  } vec_t;

  line_t       got_q[$];
  line_t       exp_q[$];
  logic [7:0]  stim_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_bytes = 0;
  int unsigned exp_pairs = 0;
  int          rdy_mode = 0;
  bit          gaps = 0;

  task automatic check_bits(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef RLE_LINE_ENCODER_STATS_EN
    check_val({tag, "_stat_bytes"}, stat_bytes, exp_bytes);
    check_val({tag, "_stat_pairs"}, stat_pairs, exp_pairs);
`else
    check_val({tag, "_stat_bytes"}, stat_bytes, 32'd0);
    check_val({tag, "_stat_pairs"}, stat_pairs, 32'd0);
`endif
  endtask

  // Reference model: split the byte list into maximal runs, cut runs at MAXC, chunk pairs into lines.
  task automatic build_expected();
    int unsigned i;
    int unsigned run;
    int unsigned left;
    int unsigned c;
    logic [PW-1:0] pairs[$];
    line_t ln;
    exp_q.delete();
    i = 0;
    while (i < stim_q.size()) begin
      run = 1;
      while (i + run < stim_q.size() && stim_q[i+run] == stim_q[i]) run++;
      left = run;
      while (left > 0) begin
        c = (left > MAXC) ? MAXC : left;
        pairs.push_back({CW'(c), stim_q[i]});
        left -= c;
      end
      i += run;
    end
    for (int unsigned k = 0; k < pairs.size(); k += NP) begin
      ln.data = '0;
      ln.num  = 0;
      for (int unsigned j = k; j < k + NP && j < pairs.size(); j++) begin
        ln.data[(j-k)*PW +: PW] = pairs[j];
        ln.num++;
      end
      ln.last = (k + NP >= pairs.size()) ? 1 : 0;
      exp_q.push_back(ln);
    end
    exp_bytes += stim_q.size();
    exp_pairs += pairs.size();
  endtask

  task automatic send_stream(input bit with_last);
    bit acc;
    int unsigned guard;
    for (int unsigned i = 0; i < stim_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      in_last  = with_last && (i == stim_q.size() - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 5000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %0d not accepted, in_ready %0d required 1", i, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_last(input string tag);
    int unsigned guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 20000) begin
      @(negedge clk);
      #1;
      foreach (got_q[i]) if (got_q[i].last != 0) done = 1'b1;
      guard++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_wait_last: no closing line seen, got %0d lines required one with out_last", tag, got_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_lines(input string tag);
    check_val({tag, "_lines"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_bits({tag, "_data"}, got_q[i].data, exp_q[i].data);
      check_val({tag, "_num"}, got_q[i].num, exp_q[i].num);
      check_val({tag, "_last"}, got_q[i].last, exp_q[i].last);
    end
    got_q.delete();
  endtask

  task automatic do_reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_bytes = 0;
    exp_pairs = 0;
    got_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: records every handshaken line and checks that a stalled line holds still.
  initial begin
    line_t ln;
    logic [DW-1:0] hd;
    logic [31:0] hmeta;
    bit ps;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          check_val("hold_valid", {31'd0, out_valid}, 32'd1);
          check_bits("hold_data", out_data, hd);
          check_val("hold_meta", {25'd0, out_last, out_num_pairs}, hmeta);
        end
        if (out_valid && out_ready) begin
          ln.data = out_data;
          ln.num  = 32'(out_num_pairs);
          ln.last = 32'(out_last);
          got_q.push_back(ln);
        end
        ps    = out_valid && !out_ready;
        hd    = out_data;
        hmeta = {25'd0, out_last, out_num_pairs};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [DW-1:0] ed;
    int unsigned nr;
    int unsigned len;
    logic [7:0] v;

    vt[0] = '{2, '{8'h41, 8'h42, 8'h00}, '{3, 1, 0},   2, '{16'h0341, 16'h0142, 16'h0000}, 1};
    vt[1] = '{1, '{8'h00, 8'h00, 8'h00}, '{300, 0, 0}, 2, '{16'hFF00, 16'h2D00, 16'h0000}, 1};
    vt[2] = '{1, '{8'h07, 8'h00, 8'h00}, '{1, 0, 0},   1, '{16'h0107, 16'h0000, 16'h0000}, 1};
    vt[3] = '{1, '{8'h55, 8'h00, 8'h00}, '{255, 0, 0}, 1, '{16'hFF55, 16'h0000, 16'h0000}, 1};
    vt[4] = '{1, '{8'h55, 8'h00, 8'h00}, '{256, 0, 0}, 2, '{16'hFF55, 16'h0155, 16'h0000}, 1};
    vt[5] = '{3, '{8'hAA, 8'hBB, 8'hAA}, '{2, 1, 1},   3, '{16'h02AA, 16'h01BB, 16'h01AA}, 1};
    vt[6] = '{1, '{8'hC3, 8'h00, 8'h00}, '{510, 0, 0}, 2, '{16'hFFC3, 16'hFFC3, 16'h0000}, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_bits("rst_out_data", out_data, '0);
    check_val("rst_out_last", {31'd0, out_last}, 32'd0);
    check_val("rst_num_pairs", 32'(out_num_pairs), 32'd0);
    check_stats("rst");
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) begin
      stim_q.delete();
      for (int unsigned r = 0; r < vt[t].nr; r++)
        repeat (vt[t].len[r]) stim_q.push_back(vt[t].val[r]);
      send_stream(1'b1);
      wait_last($sformatf("vec%0d", t));
      ed = '0;
      for (int unsigned k = 0; k < vt[t].num; k++) ed[k*PW +: PW] = vt[t].p[k];
      exp_bytes += stim_q.size();
      exp_pairs += vt[t].num;
      check_val($sformatf("vec%0d_lines", t), got_q.size(), 32'd1);
      if (got_q.size() > 0) begin
        check_bits($sformatf("vec%0d_data", t), got_q[0].data, ed);
        check_val($sformatf("vec%0d_num", t), got_q[0].num, vt[t].num);
        check_val($sformatf("vec%0d_last", t), got_q[0].last, vt[t].last);
      end
      check_stats($sformatf("vec%0d", t));
      got_q.delete();
    end

    // 33 distinct bytes: a full line without out_last, then the tail alone on a second line.
    stim_q.delete();
    for (int k = 0; k <= 32; k++) stim_q.push_back(8'(k));
    send_stream(1'b1);
    wait_last("distinct33");
    exp_bytes += 33;
    exp_pairs += 33;
    check_val("distinct33_lines", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      ed = '0;
      for (int k = 0; k < 32; k++) ed[k*PW +: PW] = {8'h01, 8'(k)};
      check_bits("distinct33_l1_data", got_q[0].data, ed);
      check_val("distinct33_l1_num", got_q[0].num, 32'd32);
      check_val("distinct33_l1_last", got_q[0].last, 32'd0);
      ed = '0;
      ed[15:0] = 16'h0120;
      check_bits("distinct33_l2_data", got_q[1].data, ed);
      check_val("distinct33_l2_num", got_q[1].num, 32'd1);
      check_val("distinct33_l2_last", got_q[1].last, 32'd1);
    end
    check_stats("distinct33");
    got_q.delete();

    // Full line held by out_ready low for 10 cycles; input must stall and nothing may be lost.
    rdy_mode  = 2;
    out_ready = 1'b0;
    stim_q.delete();
    for (int k = 0; k < 32; k++) stim_q.push_back(8'(8'h80 + k));
    repeat (8) stim_q.push_back(8'h99);
    build_expected();
    fork
      send_stream(1'b1);
      begin
        int unsigned g;
        g = 0;
        while (!out_valid && g < 500) begin
          @(negedge clk);
          g++;
        end
        check_val("bp_full_valid", {31'd0, out_valid}, 32'd1);
        repeat (10) begin
          @(negedge clk);
          check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check_bits("bp_data", out_data, exp_q[0].data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rdy_mode  = 0;
      end
    join
    wait_last("bp");
    compare_lines("bp");
    check_stats("bp");

    // Reset in the middle of an open run: nothing from the discarded run may appear.
    stim_q.delete();
    repeat (5) stim_q.push_back(8'h33);
    send_stream(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("midrun_no_line", got_q.size(), 32'd0);
    check_val("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    do_reset_pulse();
    stim_q.delete();
    stim_q.push_back(8'h07);
    build_expected();
    send_stream(1'b1);
    wait_last("after_rst");
    check_val("after_rst_lines", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_val("after_rst_pair", got_q[0].data[31:0], 32'h0000_0107);
    compare_lines("after_rst");
    check_stats("after_rst");

    // Reset asserted mid-cycle while a line is pending: outputs clear without waiting for a clock.
    rdy_mode  = 2;
    out_ready = 1'b0;
    stim_q.delete();
    stim_q.push_back(8'h41);
    stim_q.push_back(8'h41);
    stim_q.push_back(8'h42);
    send_stream(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_val("pend_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_out_valid", {31'd0, out_valid}, 32'd0);
    check_bits("async_out_data", out_data, '0);
    check_val("async_out_last", {31'd0, out_last}, 32'd0);
    check_val("async_num_pairs", 32'(out_num_pairs), 32'd0);
    exp_bytes = 0;
    exp_pairs = 0;
    check_stats("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    @(negedge clk);
    check_val("async_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("async_rel_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 0;

    // Randomized streams with idle gaps and random back-pressure.
    rdy_mode = 1;
    gaps     = 1'b1;
    for (int s = 0; s < 20; s++) begin
      stim_q.delete();
      nr = $urandom_range(1, 60);
      for (int unsigned r = 0; r < nr; r++) begin
        v   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        len = ($urandom_range(0, 19) == 0) ? $urandom_range(200, 600) : $urandom_range(1, 4);
        repeat (len) stim_q.push_back(v);
      end
      build_expected();
      send_stream(1'b1);
      wait_last($sformatf("rnd%0d", s));
      compare_lines($sformatf("rnd%0d", s));
      check_stats($sformatf("rnd%0d", s));
    end
    rdy_mode = 0;
    gaps     = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rle_line_encoder.md
# rle_line_encoder

Byte-stream run-length encoder that sits directly upstream of the host-memory write stage in the RLE AFU. It consumes an 8-bit symbol stream with valid/ready handshake, collapses consecutive equal bytes into (count, value) pairs, and packs pairs into full-width lines. Each line is presented on a valid/ready output that the DMA writer turns into one `wr_write` burst of length 1.

## Interface
- `DATA_WIDTH`, 512: output line width; equals host channel line width.
- `COUNT_WIDTH`, 8: run-count field width; max run = 2^COUNT_WIDTH-1. Legal 1..16.
- Derived, not overridable: `PAIR_W = 8+COUNT_WIDTH`, `PAIRS = DATA_WIDTH/PAIR_W` (32 at defaults).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block accepts byte this cycle.
- `in_data`  in  8  symbol.
- `in_last`  in  1  final byte of stream; qualified by `in_valid`.
- `out_valid`  out  1  line valid.
- `out_ready`  in  1  downstream writer accepts line.
- `out_data`  out  DATA_WIDTH  packed pairs; pair k at bits [k*PAIR_W +: PAIR_W], `{count, value}`, value in low byte; unused bits zero.
- `out_last`  out  1  line closes the stream.
- `out_num_pairs`  out  $clog2(PAIRS+1)  valid pairs in line, 1..PAIRS when `out_valid`.
- `stat_pairs`  out  32  total pairs emitted since reset (see Configuration).
- `stat_bytes`  out  32  total bytes accepted since reset (see Configuration).

## Operation
- Accept = `in_valid && in_ready`. `in_ready = !out_valid && state != TAIL` (combinational).
- Internal: current run `cur_val`, `cur_cnt`; line buffer; slot index `n`.
- States:
  - IDLE: no run open. On accept: `cur_val<=in_data`, `cur_cnt<=1`; go RUN, or TAIL if `in_last`.
  - RUN: on accept, if `in_data==cur_val && cur_cnt<MAX`, increment `cur_cnt`. Otherwise append pair {cur_cnt, cur_val} at slot n, n++, and open new run (in_data, 1). If `in_last`, go TAIL.
  - TAIL: when `!out_valid`, append current run pair, assert `out_valid` with `out_last=1`, go IDLE.
- Line-full rule: an append making n==PAIRS sets `out_valid=1` and `out_last=0` in the same edge.
- Output handshake: `out_valid && out_ready` clears line buffer to zero, n to 0, `out_valid` and `out_last` to 0.
- Run splitting: a run longer than MAX is emitted as successive MAX pairs plus remainder; the remainder is never zero.
- `out_data`, `out_last` and `out_num_pairs` are held stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync-safe deassert on `clk`): state IDLE, `out_valid=0`, `out_data=0`, `out_last=0`, `out_num_pairs=0`, stats 0, run registers 0. `in_ready=1` in the first cycle after reset.
- Reset mid-stream discards the open run and any unsent line without emitting them.
- A pair closed by the byte accepted at edge N is in the buffer after edge N. If that pair fills the line, `out_valid` is high in the cycle following edge N.
- `in_last` accepted at edge N: TAIL during cycle N+1. Tail pair appended and `out_valid=1`, `out_last=1` after edge N+1, provided the line was not full.
- Full line at edge N: the closing pair fills the line, TAIL waits for the output handshake; the tail is appended on the next edge as a new 1-pair line with `out_last=1`.
- Line drained at edge M: `in_ready` is high in cycle M+1. Sustained throughput is 1 byte/cycle except for 1 stall cycle per line and 1 per TAIL.

## Configuration
- `RLE_LINE_ENCODER_STATS_EN`:
  - Defined: `stat_pairs` increments on every append and `stat_bytes` on every accept. Both wrap modulo 2^32.
  - Undefined: no counters are synthesized and both outputs are constant 0.

## Test plan
- Reset: assert `reset` mid-cycle -> all outputs 0 immediately; after release, `in_ready=1`, `out_valid=0`.
- Bytes 0x41,0x41,0x41,0x42(last) -> one line: `out_num_pairs=2`, `out_data[15:0]=0x0341`, `[31:16]=0x0142`, upper bits 0, `out_last=1`.
- 300 × 0x00 with last -> pairs 0xFF00, 0x2D00; `out_num_pairs=2`, `out_last=1`; `stat_bytes=300`, `stat_pairs=2` with STATS_EN.
- 33 distinct bytes 0x00..0x20, last on 0x20 -> line 1 has 32 pairs (0x0100..0x011F) with `out_last=0`; line 2 has 1 pair 0x0120 with `out_last=1`.
- Full line with `out_ready` low for 10 cycles -> `in_ready=0`, `out_data` stable, no byte lost; after handshake, the next bytes encode correctly.
- Reset asserted after 5 bytes of an open run -> no line emitted; a new stream 0x07(last) yields a single pair 0x0107.
